// File: rtl/soc_system_stream_writer_pkg.sv
// Shared definitions for the stream-to-memory writer: CSR map, register bit
// positions, FSM state encoding and the default memory geometry.
package soc_system_stream_writer_pkg;

   localparam int DEF_MEM_AW = 10;
   localparam int DEF_MEM_DW = 32;
   localparam int CSR_W      = 32;

   localparam logic [1:0] CSR_CONTROL = 2'd0;
   localparam logic [1:0] CSR_BASE    = 2'd1;
   localparam logic [1:0] CSR_LENGTH  = 2'd2;
   localparam logic [1:0] CSR_STATUS  = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_OVERFLOW = 2;
   localparam int STAT_WW_LSB   = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SOP,
      ST_PACK,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/soc_system_stream_writer_if.sv
// Bus bundle for the writer: CSR slave, Avalon-ST byte sink and the
// Avalon-MM write port towards the on-chip memory.
interface soc_system_stream_writer_if
   import soc_system_stream_writer_pkg::*;
#(
   parameter int MEM_AW = DEF_MEM_AW,
   parameter int MEM_DW = DEF_MEM_DW
);
   logic [1:0]          csr_address;
   logic                csr_write;
   logic [CSR_W-1:0]    csr_writedata;
   logic                csr_read;
   logic [CSR_W-1:0]    csr_readdata;

   logic [7:0]          sink_data;
   logic                sink_valid;
   logic                sink_ready;
   logic                sink_startofpacket;
   logic                sink_endofpacket;

   logic [MEM_AW-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_write;
   logic [MEM_DW/8-1:0] mem_byteenable;
   logic [MEM_DW-1:0]   mem_writedata;

   // Bridge side
   modport slave (
      input  csr_address, csr_write, csr_writedata, csr_read,
      output csr_readdata,
      input  sink_data, sink_valid, sink_startofpacket, sink_endofpacket,
      output sink_ready,
      output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata
   );

   // Host / stream source / memory side
   modport master (
      output csr_address, csr_write, csr_writedata, csr_read,
      input  csr_readdata,
      output sink_data, sink_valid, sink_startofpacket, sink_endofpacket,
      input  sink_ready,
      input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata
   );

endinterface

// File: rtl/soc_system_byte_packer.sv
// Little-endian byte packer: places each accepted byte into the next lane of
// a word and reports when the word leaves, either full (commit) or cut short
// by end-of-packet (flush). The word and byteenable outputs are valid in the
// same cycle as commit/flush so the caller can register them directly.
module soc_system_byte_packer
   import soc_system_stream_writer_pkg::*;
#(
   parameter int MEM_DW = DEF_MEM_DW
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                byte_valid,
   input  logic [7:0]          byte_data,
   input  logic                byte_last,
   input  logic                clear,
   output logic                commit,
   output logic                flush,
   output logic [MEM_DW-1:0]   word,
   output logic [MEM_DW/8-1:0] byteenable
);
   localparam int LANES  = MEM_DW / 8;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LANE_W-1:0] lane_cnt;
   logic [MEM_DW-1:0] shift_reg;

   // Lanes 0..cnt are filled once the current byte lands in lane cnt.
   function automatic logic [LANES-1:0] lane_mask(input logic [LANE_W-1:0] cnt);
      lane_mask = LANES'((32'd1 << (32'(cnt) + 32'd1)) - 32'd1);
   endfunction

   // Insert the incoming byte into its lane and decide whether the word leaves now
   always_comb begin
      word                     = shift_reg;
      word[lane_cnt * 8 +: 8]  = byte_data;
      commit                   = byte_valid && (lane_cnt == LANE_W'(LANES - 1));
      flush                    = byte_valid && byte_last && !commit;
      byteenable               = lane_mask(lane_cnt);
   end

   // Lane counter and partial word; an outgoing word reloads the packer with no bubble
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lane_cnt  <= '0;
         shift_reg <= '0;
      end else if (clear || commit || flush) begin
         lane_cnt  <= '0;
         shift_reg <= '0;
      end else if (byte_valid) begin
         lane_cnt  <= lane_cnt + 1'b1;
         shift_reg <= word;
      end
   end

endmodule

// File: rtl/soc_system_stream_writer.sv
// Avalon-ST byte stream to Avalon-MM memory writer. Software programs a
// word window (BASE/LENGTH) and starts a transfer; one packet is packed into
// 32-bit words and written to the window, wrapping at the memory size.
module soc_system_stream_writer
   import soc_system_stream_writer_pkg::*;
#(
   parameter int MEM_AW = DEF_MEM_AW,
   parameter int MEM_DW = DEF_MEM_DW
) (
   input  logic                      clk,
   input  logic                      reset_n,
   soc_system_stream_writer_if.slave bus
);
   localparam int                CNT_W   = MEM_AW + 1;
   localparam int                LANES   = MEM_DW / 8;
   localparam logic [CNT_W-1:0]  MAX_LEN = CNT_W'(2 ** MEM_AW);

   state_t            state, state_nxt;
   logic [MEM_AW-1:0] base_reg, base_lat;
   logic [CNT_W-1:0]  length_reg, len_lat, words_written;
   logic              done, overflow;

   logic              ctrl_wr, start_req, abort_req;
   logic              accept, pack_valid, budget_hit, mem_wr;
   logic              set_done, set_overflow;
   logic              pk_commit, pk_flush;
   logic [MEM_DW-1:0] pk_word;
   logic [LANES-1:0]  pk_be;
   logic [CSR_W-1:0]  status_word;

   // ABORT has priority over START when both bits arrive in one write
   assign ctrl_wr   = bus.csr_write && (bus.csr_address == CSR_CONTROL);
   assign abort_req = ctrl_wr && bus.csr_writedata[CTRL_ABORT] && (state != ST_IDLE);
   assign start_req = ctrl_wr && bus.csr_writedata[CTRL_START] && !bus.csr_writedata[CTRL_ABORT]
                      && (state == ST_IDLE) && (length_reg != '0);

   assign bus.sink_ready = (state != ST_IDLE);
   assign accept         = bus.sink_valid && bus.sink_ready;
   assign pack_valid     = accept && ((state == ST_PACK) ||
                                      ((state == ST_WAIT_SOP) && bus.sink_startofpacket));
   assign mem_wr         = pk_commit || pk_flush;
   assign budget_hit     = (words_written + 1'b1) == len_lat;

   soc_system_byte_packer #(
      .MEM_DW (MEM_DW)
   ) u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .byte_valid (pack_valid),
      .byte_data  (bus.sink_data),
      .byte_last  (bus.sink_endofpacket),
      .clear      (start_req || abort_req),
      .commit     (pk_commit),
      .flush      (pk_flush),
      .word       (pk_word),
      .byteenable (pk_be)
   );

   // Next-state and status-flag decisions; EOP takes precedence over budget exhaustion
   always_comb begin
      state_nxt    = state;
      set_done     = 1'b0;
      set_overflow = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_req) state_nxt = ST_WAIT_SOP;
         end
         ST_WAIT_SOP, ST_PACK: begin
            if (pack_valid) begin
               state_nxt = ST_PACK;
               if (mem_wr && bus.sink_endofpacket) begin
                  state_nxt = ST_IDLE;
                  set_done  = 1'b1;
               end else if (mem_wr && budget_hit) begin
                  state_nxt    = ST_DRAIN;
                  set_overflow = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (accept && bus.sink_endofpacket) begin
               state_nxt = ST_IDLE;
               set_done  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (abort_req) begin
         state_nxt = ST_IDLE;
         set_done  = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Live BASE/LENGTH registers and the window captured at START
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_reg   <= '0;
         length_reg <= '0;
         base_lat   <= '0;
         len_lat    <= '0;
      end else begin
         if (bus.csr_write && (bus.csr_address == CSR_BASE))
            base_reg <= bus.csr_writedata[MEM_AW-1:0];
         if (bus.csr_write && (bus.csr_address == CSR_LENGTH))
            length_reg <= bus.csr_writedata[CNT_W-1:0];
         if (start_req) begin
            base_lat <= base_reg;
            len_lat  <= (length_reg > MAX_LEN) ? MAX_LEN : length_reg;
         end
      end
   end

   // Completion flags and written-word count; a word leaving in an abort cycle still counts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done          <= 1'b0;
         overflow      <= 1'b0;
         words_written <= '0;
      end else if (start_req) begin
         done          <= 1'b0;
         overflow      <= 1'b0;
         words_written <= '0;
      end else begin
         if (mem_wr)       words_written <= words_written + 1'b1;
         if (set_done)     done          <= 1'b1;
         if (set_overflow) overflow      <= 1'b1;
      end
   end

   // Memory write port: one-cycle pulse the cycle after the committing beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.mem_write      <= 1'b0;
         bus.mem_chipselect <= 1'b0;
         bus.mem_address    <= '0;
         bus.mem_byteenable <= '0;
         bus.mem_writedata  <= '0;
      end else begin
         bus.mem_write      <= mem_wr;
         bus.mem_chipselect <= mem_wr;
         if (mem_wr) begin
            bus.mem_address    <= base_lat + words_written[MEM_AW-1:0];
            bus.mem_byteenable <= pk_be;
            bus.mem_writedata  <= pk_word;
         end
      end
   end

   // STATUS word assembly
   always_comb begin
      status_word                                = '0;
      status_word[STAT_BUSY]                     = (state != ST_IDLE);
      status_word[STAT_DONE]                     = done;
      status_word[STAT_OVERFLOW]                 = overflow;
      status_word[STAT_WW_LSB +: CNT_W]          = words_written;
   end

   // Registered CSR read port, one cycle of latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.csr_readdata <= '0;
      end else if (bus.csr_read) begin
         case (bus.csr_address)
            CSR_BASE:   bus.csr_readdata <= CSR_W'(base_reg);
            CSR_LENGTH: bus.csr_readdata <= CSR_W'(length_reg);
            CSR_STATUS: bus.csr_readdata <= status_word;
            default:    bus.csr_readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_soc_system_stream_writer.sv
// Bench for the stream writer: directed packets drive the sink while a
// scoreboard queue of expected memory writes is consumed by a monitor.
module tb_soc_system_stream_writer;
   import soc_system_stream_writer_pkg::*;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   tests = 0;
   int   fails = 0;
   wr_t  exp_q[$];
   wr_t  mon_e;
   logic [31:0] rd;

   always #5 clk = ~clk;

   soc_system_stream_writer_if #(.MEM_AW(10), .MEM_DW(32)) bus ();

   soc_system_stream_writer #(.MEM_AW(10), .MEM_DW(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      exp_q.push_back('{addr: a, data: d, be: be});
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      bus.csr_address   = a;
      bus.csr_writedata = d;
      bus.csr_write     = 1'b1;
      @(posedge clk); #1;
      bus.csr_write     = 1'b0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      bus.csr_address = a;
      bus.csr_read    = 1'b1;
      @(posedge clk); #1;
      bus.csr_read    = 1'b0;
      d = bus.csr_readdata;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
      int waits;
      bus.sink_data          = d;
      bus.sink_valid         = 1'b1;
      bus.sink_startofpacket = sop;
      bus.sink_endofpacket   = eop;
      check("sink_ready", 32'(bus.sink_ready), 32'd1);
      waits = 0;
      while (!bus.sink_ready && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      @(posedge clk); #1;
      bus.sink_valid         = 1'b0;
      bus.sink_startofpacket = 1'b0;
      bus.sink_endofpacket   = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] first, input int n, input logic sop_first,
                             input logic eop_last);
      for (int i = 0; i < n; i++)
         send_beat(first + 8'(i), sop_first && (i == 0), eop_last && (i == n - 1));
   endtask

   task automatic start_window(input logic [9:0] base, input logic [10:0] len);
      csr_wr(CSR_BASE, 32'(base));
      csr_wr(CSR_LENGTH, 32'(len));
      csr_wr(CSR_CONTROL, 32'h1);
   endtask

   // Scoreboard monitor: every memory write pops and compares one expected entry
   always @(negedge clk) begin
      if (bus.mem_write || bus.mem_chipselect)
         check("cs_with_write", 32'(bus.mem_chipselect), 32'(bus.mem_write));
      if (bus.mem_write) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr=%h data=%h be=%h required no write",
                     bus.mem_address, bus.mem_writedata, bus.mem_byteenable);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(bus.mem_address), 32'(mon_e.addr));
            check("wr_data", bus.mem_writedata, mon_e.data);
            check("wr_be", 32'(bus.mem_byteenable), 32'(mon_e.be));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.csr_address        = '0;
      bus.csr_write          = 1'b0;
      bus.csr_writedata      = '0;
      bus.csr_read           = 1'b0;
      bus.sink_data          = '0;
      bus.sink_valid         = 1'b0;
      bus.sink_startofpacket = 1'b0;
      bus.sink_endofpacket   = 1'b0;

      // Power-on reset
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sink_ready", 32'(bus.sink_ready), 32'd0);
      check("rst_mem_write", 32'(bus.mem_write), 32'd0);
      check("rst_readdata", bus.csr_readdata, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      csr_rd(CSR_STATUS, rd);
      check("rst_status", rd, 32'h0);

      // START with LENGTH=0 is ignored
      csr_wr(CSR_CONTROL, 32'h1);
      check("len0_ready", 32'(bus.sink_ready), 32'd0);
      csr_rd(CSR_STATUS, rd);
      check("len0_status", rd, 32'h0);

      // Two full words at 0x010
      start_window(10'h010, 11'd4);
      exp_wr(10'h010, 32'h04030201, 4'hF);
      exp_wr(10'h011, 32'h08070605, 4'hF);
      send_bytes(8'h01, 8, 1'b1, 1'b1);
      check("eop_ready_low", 32'(bus.sink_ready), 32'd0);
      csr_rd(CSR_STATUS, rd);
      check("t1_status", rd, 32'h00020002);

      // START and ABORT together: nothing starts, done is kept
      csr_wr(CSR_CONTROL, 32'h3);
      csr_rd(CSR_STATUS, rd);
      check("start_abort_status", rd, 32'h00020002);

      // Partial last word
      csr_wr(CSR_CONTROL, 32'h1);
      exp_wr(10'h010, 32'hA3A2A1A0, 4'hF);
      exp_wr(10'h011, 32'h0000A5A4, 4'h3);
      send_bytes(8'hA0, 6, 1'b1, 1'b1);
      csr_rd(CSR_STATUS, rd);
      check("t2_status", rd, 32'h00020002);

      // Address wrap at the top of memory
      start_window(10'h3FF, 11'd2);
      exp_wr(10'h3FF, 32'h13121110, 4'hF);
      exp_wr(10'h000, 32'h17161514, 4'hF);
      send_bytes(8'h10, 8, 1'b1, 1'b1);
      csr_rd(CSR_STATUS, rd);
      check("t3_status", rd, 32'h00020002);

      // Budget of one word: overflow, drain until EOP
      start_window(10'h020, 11'd1);
      exp_wr(10'h020, 32'h23222120, 4'hF);
      send_bytes(8'h20, 6, 1'b1, 1'b0);
      csr_rd(CSR_STATUS, rd);
      check("t4_mid_status", rd, 32'h00010005);
      send_bytes(8'h26, 4, 1'b0, 1'b1);
      csr_rd(CSR_STATUS, rd);
      check("t4_status", rd, 32'h00010006);

      // Junk before SOP, then ABORT mid-word
      start_window(10'h100, 11'd4);
      send_bytes(8'hE0, 2, 1'b0, 1'b0);
      send_beat(8'hE2, 1'b0, 1'b1);
      exp_wr(10'h100, 32'h43424140, 4'hF);
      send_bytes(8'h40, 6, 1'b1, 1'b0);
      csr_wr(CSR_CONTROL, 32'h2);
      check("abort_ready", 32'(bus.sink_ready), 32'd0);
      csr_rd(CSR_STATUS, rd);
      check("t5_status", rd, 32'h00010000);
      repeat (5) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a packet
      start_window(10'h200, 11'd4);
      exp_wr(10'h200, 32'h53525150, 4'hF);
      send_bytes(8'h50, 4, 1'b1, 1'b0);
      csr_rd(CSR_STATUS, rd);
      check("t6_mid_status", rd, 32'h00010001);
      send_beat(8'h54, 1'b0, 1'b0);
      bus.sink_data  = 8'h55;
      bus.sink_valid = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("arst_sink_ready", 32'(bus.sink_ready), 32'd0);
      check("arst_mem_write", 32'(bus.mem_write), 32'd0);
      check("arst_mem_cs", 32'(bus.mem_chipselect), 32'd0);
      check("arst_mem_address", 32'(bus.mem_address), 32'd0);
      check("arst_mem_be", 32'(bus.mem_byteenable), 32'd0);
      check("arst_mem_wdata", bus.mem_writedata, 32'd0);
      check("arst_readdata", bus.csr_readdata, 32'd0);
      bus.sink_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      csr_rd(CSR_STATUS, rd);
      check("post_rst_status", rd, 32'h0);
      csr_rd(CSR_BASE, rd);
      check("post_rst_base", rd, 32'h0);
      csr_rd(CSR_LENGTH, rd);
      check("post_rst_length", rd, 32'h0);

      repeat (5) @(posedge clk);
      #1;
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
